bridge_16_32: RTL and testbench

- 16-bit responder that terminates the 16-bit bridge bus. It converts each 16-bit read or write into one 32-bit access on a 32-bit target port.
- Sits between the 32-to-16 bridge output and 32-bit memory or peripheral fabric.
- Holds a one-word read-merge buffer. The second halfword of a split 32-bit read completes without a second target access.

---
 rtl/bridge_pkg.sv | 24 ++
 rtl/bridge_16_32_if.sv | 26 ++
 rtl/bridge_read_buf.sv | 46 ++++
 rtl/bridge_16_32.sv | 111 +++++++++++
 tb/tb_bridge_16_32.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bridge_pkg.sv
// Shared types and helpers for the 16-to-32 bridge responder.
package bridge_pkg;

  localparam int ADDR_W   = 32;
  localparam int S_DATA_W = 16;
  localparam int M_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Steer halfword byte enables onto the word lanes selected by address bit 1.
  function automatic logic [3:0] steer_bytesel(input logic hi, input logic [1:0] bsel);
    return hi ? {bsel, 2'b00} : {2'b00, bsel};
  endfunction

  // Pick one halfword out of a 32-bit word (hi=1 selects bits [31:16]).
  function automatic logic [15:0] half_sel(input logic hi, input logic [31:0] word);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/bridge_16_32_if.sv
// Request/completion bus used on both the 16-bit and the 32-bit side.
interface bridge_16_32_if
  import bridge_pkg::*;
#(
  parameter int DATA_W = S_DATA_W
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              wr_en;
  logic [BE_W-1:0]   bytesel;
  logic              compl;

  modport master (
    output addr, wdata, wr_en, bytesel,
    input  rdata, compl
  );

  modport slave (
    input  addr, wdata, wr_en, bytesel,
    output rdata, compl
  );

endinterface

// File: rtl/bridge_read_buf.sv
// One-word read-merge buffer: tag/data/valid with hit compare, fill and invalidate.
module bridge_read_buf
  import bridge_pkg::*;
#(
  parameter bit ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lookup_tag,
  input  logic        lookup_hi,
  output logic        hit,
  output logic [15:0] lookup_half,
  input  logic        fill_en,
  input  logic [29:0] fill_tag,
  input  logic [31:0] fill_data,
  input  logic        inv_en,
  input  logic [29:0] inv_tag
);

  logic        valid;
  logic [29:0] tag;
  logic [31:0] data;

  assign hit         = ENABLE && valid && (tag == lookup_tag);
  assign lookup_half = half_sel(lookup_hi, data);

  // Valid bit: set by a fill, cleared by a write to the buffered word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (fill_en && ENABLE) begin
      valid <= 1'b1;
    end else if (inv_en && valid && (tag == inv_tag)) begin
      valid <= 1'b0;
    end
  end

  // Tag and data carry no reset; they are qualified by valid.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag  <= fill_tag;
      data <= fill_data;
    end
  end

endmodule

// File: rtl/bridge_16_32.sv
// 16-bit bus responder that turns each halfword access into one 32-bit
// target access, answering the second half of a split read from a buffer.
module bridge_16_32
  import bridge_pkg::*;
#(
  parameter bit READ_MERGE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  bridge_16_32_if.slave   s,
  bridge_16_32_if.master  m
);

  state_t      state;
  logic        lat_hi;
  logic [15:0] s_rdata_q;
  logic        s_compl_q;
  logic [31:0] m_addr_q;
  logic [31:0] m_wdata_q;
  logic        m_wr_en_q;
  logic [3:0]  m_bytesel_q;

  logic        req;
  logic        hit;
  logic [15:0] hit_half;
  logic        fill_en;
  logic        inv_en;

  assign req     = (s.bytesel != 2'b00);
  assign fill_en = (state == ACCESS) && m.compl && !m_wr_en_q;
  assign inv_en  = (state == ACCESS) && m.compl && m_wr_en_q;

  assign s.rdata   = s_rdata_q;
  assign s.compl   = s_compl_q;
  assign m.addr    = m_addr_q;
  assign m.wdata   = m_wdata_q;
  assign m.wr_en   = m_wr_en_q;
  assign m.bytesel = m_bytesel_q;

  // m_addr_q holds the latched word address for the whole access, so it
  // doubles as the fill/invalidate tag.
  bridge_read_buf #(
    .ENABLE (READ_MERGE)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .lookup_tag  (s.addr[31:2]),
    .lookup_hi   (s.addr[1]),
    .hit         (hit),
    .lookup_half (hit_half),
    .fill_en     (fill_en),
    .fill_tag    (m_addr_q[31:2]),
    .fill_data   (m.rdata),
    .inv_en      (inv_en),
    .inv_tag     (m_addr_q[31:2])
  );

  // Request FSM: accept in IDLE, run the target access, pulse completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      lat_hi      <= 1'b0;
      s_rdata_q   <= 16'h0000;
      s_compl_q   <= 1'b0;
      m_addr_q    <= 32'h0000_0000;
      m_wdata_q   <= 32'h0000_0000;
      m_wr_en_q   <= 1'b0;
      m_bytesel_q <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_hi <= s.addr[1];
            if (!s.wr_en && hit) begin
              s_rdata_q <= hit_half;
              s_compl_q <= 1'b1;
              state     <= RESP;
            end else begin
              m_addr_q  <= {s.addr[31:2], 2'b00};
              m_wr_en_q <= s.wr_en;
              if (s.wr_en) begin
                m_wdata_q   <= {s.wdata, s.wdata};
                m_bytesel_q <= steer_bytesel(s.addr[1], s.bytesel);
              end else begin
                // Full-word read so the buffer can serve the other half.
                m_bytesel_q <= 4'b1111;
              end
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (m.compl) begin
            m_bytesel_q <= 4'b0000;
            m_wr_en_q   <= 1'b0;
            s_compl_q   <= 1'b1;
            s_rdata_q   <= m_wr_en_q ? 16'h0000 : half_sel(lat_hi, m.rdata);
            state       <= RESP;
          end
        end
        RESP: begin
          s_compl_q <= 1'b0;
          s_rdata_q <= 16'h0000;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bridge_16_32.sv
// Directed bench for bridge_16_32 with a delay-programmable target model.
module tb_bridge_16_32;
  import bridge_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bridge_16_32_if #(.DATA_W(16)) s0 ();
  bridge_16_32_if #(.DATA_W(32)) m0 ();
  bridge_16_32_if #(.DATA_W(16)) s1 ();
  bridge_16_32_if #(.DATA_W(32)) m1 ();

  bridge_16_32 #(.READ_MERGE(1'b1)) dut0 (.clk(clk), .rst(rst), .s(s0), .m(m0));
  bridge_16_32 #(.READ_MERGE(1'b0)) dut1 (.clk(clk), .rst(rst), .s(s1), .m(m1));

  // Stimulus shared by both DUTs; sel routes the request to one of them.
  logic        sel;
  logic [31:0] addr_d;
  logic [15:0] wd_d;
  logic        wr_d;
  logic [1:0]  bs_d;
  logic [31:0] tgt_data;
  int          tgt_delay;

  logic cmpl_d  = 1'b0;
  int   wait_cnt = 0;
  int   acc_cnt  = 0;
  int   cyc      = 0;
  int   mc_cyc   = 0;

  assign s0.addr    = addr_d;
  assign s0.wdata   = wd_d;
  assign s0.wr_en   = wr_d;
  assign s0.bytesel = sel ? 2'b00 : bs_d;
  assign s1.addr    = addr_d;
  assign s1.wdata   = wd_d;
  assign s1.wr_en   = wr_d;
  assign s1.bytesel = sel ? bs_d : 2'b00;
  assign m0.rdata   = tgt_data;
  assign m1.rdata   = tgt_data;
  assign m0.compl   = cmpl_d & ~sel;
  assign m1.compl   = cmpl_d & sel;

  logic [15:0] cur_s_rdata;
  logic        cur_s_compl;
  logic [31:0] cur_m_addr;
  logic [31:0] cur_m_wdata;
  logic        cur_m_wr_en;
  logic [3:0]  cur_m_bytesel;

  assign cur_s_rdata   = sel ? s1.rdata   : s0.rdata;
  assign cur_s_compl   = sel ? s1.compl   : s0.compl;
  assign cur_m_addr    = sel ? m1.addr    : m0.addr;
  assign cur_m_wdata   = sel ? m1.wdata   : m0.wdata;
  assign cur_m_wr_en   = sel ? m1.wr_en   : m0.wr_en;
  assign cur_m_bytesel = sel ? m1.bytesel : m0.bytesel;

  always @(posedge clk) cyc <= cyc + 1;

  // Target model: completes tgt_delay cycles after the request appears.
  always @(negedge clk) begin
    if (cmpl_d) begin
      cmpl_d = 1'b0;
    end else if (cur_m_bytesel != 4'b0000) begin
      if (wait_cnt >= tgt_delay) begin
        cmpl_d   = 1'b1;
        acc_cnt  = acc_cnt + 1;
        mc_cyc   = cyc;
        wait_cnt = 0;
      end else begin
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Results of the last request.
  logic [15:0] got_rd;
  int          lat;
  int          sc_cyc;
  logic        compl_after;
  logic        snap_ok;
  logic        m_stable;
  logic [31:0] snap_addr;
  logic [31:0] snap_wdata;
  logic        snap_wr;
  logic [3:0]  snap_bs;

  task automatic do_req(input logic [31:0] a, input logic [15:0] wd, input logic wr,
                        input logic [1:0] bs, input bit perturb);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    addr_d = a; wd_d = wd; wr_d = wr; bs_d = bs;
    snap_ok = 1'b0; m_stable = 1'b1; got_rd = 16'h0000; lat = -1; compl_after = 1'bx;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (cur_m_bytesel != 4'b0000) begin
        if (!snap_ok) begin
          snap_ok = 1'b1; snap_addr = cur_m_addr; snap_wdata = cur_m_wdata;
          snap_wr = cur_m_wr_en; snap_bs = cur_m_bytesel;
        end else if (cur_m_addr != snap_addr || cur_m_wdata != snap_wdata ||
                     cur_m_wr_en != snap_wr || cur_m_bytesel != snap_bs) begin
          m_stable = 1'b0;
        end
      end
      if (perturb && c == 2) begin
        addr_d = 32'h0000_0802;
        wd_d   = 16'h1234;
      end
      if (cur_s_compl) begin
        done   = 1'b1;
        lat    = c;
        sc_cyc = cyc;
        got_rd = cur_s_rdata;
      end
    end
    check_val("req_done", {31'd0, done}, 32'd1);
    bs_d = 2'b00;
    @(negedge clk);
    compl_after = cur_s_compl;
  endtask

  int acc0;

  initial begin
    rst = 1'b1; sel = 1'b0; addr_d = '0; wd_d = '0; wr_d = 1'b0; bs_d = 2'b00;
    tgt_data = 32'h0; tgt_delay = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_s_compl",   {31'd0, cur_s_compl},   32'd0);
    check_val("rst_s_rdata",   {16'd0, cur_s_rdata},   32'd0);
    check_val("rst_m_bytesel", {28'd0, cur_m_bytesel}, 32'd0);
    check_val("rst_m_addr",    cur_m_addr,             32'd0);
    check_val("rst_m_wdata",   cur_m_wdata,            32'd0);
    check_val("rst_m_wr_en",   {31'd0, cur_m_wr_en},   32'd0);
    rst = 1'b0;

    // Reset in the middle of a slow target access.
    tgt_delay = 20;
    @(posedge clk);
    #1;
    addr_d = 32'h0000_0100; wr_d = 1'b0; bs_d = 2'b11;
    repeat (3) @(negedge clk);
    check_val("mid_bytesel", {28'd0, cur_m_bytesel}, 32'hF);
    #1 rst = 1'b1;
    #1;
    check_val("arst_m_bytesel", {28'd0, cur_m_bytesel}, 32'd0);
    check_val("arst_s_compl",   {31'd0, cur_s_compl},   32'd0);
    check_val("arst_m_addr",    cur_m_addr,             32'd0);
    @(posedge clk);
    #1;
    bs_d = 2'b00; rst = 1'b0; tgt_delay = 0;

    // Split read: first half misses, second half is served from the buffer.
    tgt_data = 32'hDEAD_BEEF;
    acc0 = acc_cnt;
    do_req(32'h0000_0100, 16'h0, 1'b0, 2'b11, 1'b0);
    check_val("rd100_bytesel", {28'd0, snap_bs}, 32'hF);
    check_val("rd100_addr",    snap_addr,        32'h0000_0100);
    check_val("rd100_data",    {16'd0, got_rd},  32'h0000_BEEF);
    check_val("rd100_lat",     lat,              32'd2);
    do_req(32'h0000_0102, 16'h0, 1'b0, 2'b11, 1'b0);
    check_val("rd102_data",    {16'd0, got_rd},  32'h0000_DEAD);
    check_val("rd102_lat",     lat,              32'd1);
    check_val("split_accesses", acc_cnt - acc0,  32'd1);

    // Upper-half write with steered byte enables.
    acc0 = acc_cnt;
    do_req(32'h0000_0206, 16'hAB00, 1'b1, 2'b10, 1'b0);
    check_val("wr206_addr",    snap_addr,          32'h0000_0204);
    check_val("wr206_bytesel", {28'd0, snap_bs},   32'h8);
    check_val("wr206_wdata",   snap_wdata,         32'hAB00_AB00);
    check_val("wr206_wr_en",   {31'd0, snap_wr},   32'd1);
    check_val("wr206_rdata",   {16'd0, got_rd},    32'd0);
    check_val("wr206_cmpl_gap", sc_cyc - mc_cyc,   32'd1);
    check_val("wr206_acc",     acc_cnt - acc0,     32'd1);

    // A write to another word keeps the buffered word valid.
    acc0 = acc_cnt;
    tgt_data = 32'h0BAD_0BAD;
    do_req(32'h0000_0100, 16'h0, 1'b0, 2'b11, 1'b0);
    check_val("rehit_data", {16'd0, got_rd}, 32'h0000_BEEF);
    check_val("rehit_lat",  lat,             32'd1);
    check_val("rehit_acc",  acc_cnt - acc0,  32'd0);

    // A write to the buffered word invalidates it.
    tgt_data = 32'h1122_3344;
    acc0 = acc_cnt;
    do_req(32'h0000_0300, 16'h0, 1'b0, 2'b11, 1'b0);
    check_val("rd300_data", {16'd0, got_rd}, 32'h0000_3344);
    do_req(32'h0000_0302, 16'h5566, 1'b1, 2'b11, 1'b0);
    check_val("wr302_bytesel", {28'd0, snap_bs}, 32'hC);
    tgt_data = 32'h5566_3344;
    do_req(32'h0000_0300, 16'h0, 1'b0, 2'b11, 1'b0);
    check_val("inval_bytesel", {28'd0, snap_bs}, 32'hF);
    check_val("inval_acc",     acc_cnt - acc0,   32'd3);
    check_val("inval_data",    {16'd0, got_rd},  32'h0000_3344);

    // Slow target with the 16-bit inputs changing mid-access.
    tgt_delay = 5;
    tgt_data  = 32'hCAFE_F00D;
    do_req(32'h0000_0400, 16'h7777, 1'b0, 2'b11, 1'b1);
    check_val("slow_addr",      snap_addr,            32'h0000_0400);
    check_val("slow_stable",    {31'd0, m_stable},    32'd1);
    check_val("slow_data",      {16'd0, got_rd},      32'h0000_F00D);
    check_val("slow_lat",       lat,                  32'd7);
    check_val("slow_cmpl_gap",  sc_cyc - mc_cyc,      32'd1);
    check_val("slow_pulse",     {31'd0, compl_after}, 32'd0);
    tgt_delay = 0;

    // Single-byte enable on a read still returns the whole halfword.
    acc0 = acc_cnt;
    do_req(32'h0000_0402, 16'h0, 1'b0, 2'b01, 1'b0);
    check_val("bs01_data", {16'd0, got_rd}, 32'h0000_CAFE);
    check_val("bs01_acc",  acc_cnt - acc0,  32'd0);

    // Merge buffer disabled: both halves go to the target.
    sel = 1'b1;
    tgt_data = 32'hDEAD_BEEF;
    acc0 = acc_cnt;
    do_req(32'h0000_0100, 16'h0, 1'b0, 2'b11, 1'b0);
    check_val("nm_rd100_addr", snap_addr,       32'h0000_0100);
    check_val("nm_rd100_data", {16'd0, got_rd}, 32'h0000_BEEF);
    do_req(32'h0000_0102, 16'h0, 1'b0, 2'b11, 1'b0);
    check_val("nm_rd102_addr", snap_addr,       32'h0000_0100);
    check_val("nm_rd102_data", {16'd0, got_rd}, 32'h0000_DEAD);
    check_val("nm_rd102_lat",  lat,             32'd2);
    check_val("nm_accesses",   acc_cnt - acc0,  32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
